// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the clock divider bank.
package clock_divider_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned MAX_WIDTH = 32;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] divisor;
    logic                 mode;
  } ch_cfg_t;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Configuration write port of the clock divider bank (valid/ready handshake).
interface clock_divider_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32
);
  import clock_divider_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_divisor,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_divisor,
    input  cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: wrap counter, shadowed divisor/mode, registered clk_out and tick.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RESET_DIV = 1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_enable,
  input  logic    i_we,
  input  ch_cfg_t i_cfg,
  output logic    o_pending,
  output logic    o_clk_out,
  output logic    o_tick
);

  logic [WIDTH-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_div, w_div_d;
  logic             r_mode, w_mode_d;
  logic             r_pend, w_pend_d;
  logic [WIDTH-1:0] r_sh_div, w_sh_div_d;
  logic             r_sh_mode, w_sh_mode_d;
  logic             r_clk_out, w_clk_out_d;
  logic             r_tick, w_tick_d;

  logic w_wrap, w_apply, w_mode_chg;

  always_comb begin
    w_wrap     = i_enable && (r_cnt == r_div);
    // Shadow takes effect only at a period boundary, or at once while idle.
    w_apply    = r_pend && (w_wrap || !i_enable);
    w_mode_chg = w_apply && (r_sh_mode != r_mode);

    w_cnt_d     = (!i_enable || w_wrap) ? '0 : r_cnt + 1'b1;
    w_tick_d    = w_wrap;
    w_div_d     = w_apply ? r_sh_div : r_div;
    w_mode_d    = w_apply ? r_sh_mode : r_mode;
    w_sh_div_d  = i_we ? i_cfg.divisor[WIDTH-1:0] : r_sh_div;
    w_sh_mode_d = i_we ? i_cfg.mode : r_sh_mode;
    w_pend_d    = i_we ? 1'b1 : (w_apply ? 1'b0 : r_pend);

    if (!i_enable || w_mode_chg) begin
      w_clk_out_d = 1'b0;
    end else if (r_mode == MODE_PULSE) begin
      w_clk_out_d = w_wrap;
    end else begin
      w_clk_out_d = w_wrap ? ~r_clk_out : r_clk_out;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_div     <= WIDTH'(RESET_DIV);
      r_mode    <= MODE_TOGGLE;
      r_pend    <= 1'b0;
      r_sh_div  <= WIDTH'(RESET_DIV);
      r_sh_mode <= MODE_TOGGLE;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_div     <= w_div_d;
      r_mode    <= w_mode_d;
      r_pend    <= w_pend_d;
      r_sh_div  <= w_sh_div_d;
      r_sh_mode <= w_sh_mode_d;
      r_clk_out <= w_clk_out_d;
      r_tick    <= w_tick_d;
    end
  end

  assign o_pending = r_pend;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent clock dividers sharing one configuration write port.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RESET_DIV = 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   enable,
  clock_divider_bank_if.slave cfg,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_we;
  logic              w_ready;
  ch_cfg_t           w_cfg;

  // Out-of-range channel numbers decode to nothing and are never ready.
  always_comb begin
    w_sel   = '0;
    w_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        w_sel[i] = 1'b1;
        w_ready  = ~w_pend[i];
      end
    end
  end

  always_comb begin
    w_cfg         = '0;
    w_cfg.divisor = MAX_WIDTH'(cfg.cfg_divisor);
    w_cfg.mode    = cfg.cfg_mode;
  end

  assign cfg.cfg_ready = w_ready;
  assign w_we          = w_sel & {NUM_CH{cfg.cfg_valid & w_ready}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .i_clk     (clk_in),
      .i_rst     (rst),
      .i_enable  (enable[g]),
      .i_we      (w_we[g]),
      .i_cfg     (w_cfg),
      .o_pending (w_pend[g]),
      .o_clk_out (clk_out[g]),
      .o_tick    (tick[g])
    );
  end

endmodule
